// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction memory request/response, redirect strobe
// and the decode-side buffer head.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: one outstanding imem request, 2-entry {pc, instr}
// buffer towards decode, redirect flushes the buffer and drops in-flight data.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] inflight_pc_r;
  logic [1:0]  count_r;
  logic [1:0]  count_next_s;
  logic        valid_r;
  logic [31:0] head_pc_r;
  logic [31:0] head_instr_r;
  logic [31:0] tail_pc_r;
  logic [31:0] tail_instr_r;
  logic        req_fire_s;
  logic        push_s;
  logic        pop_s;
  logic        unused_lsb_s;

  // Request side depends on registered state only, never on imem_req_ready.
  assign bus.imem_req_valid = (state_r == REQ) && (count_r < 2'd2);
  assign bus.imem_addr      = pc_r;
  assign bus.if_valid       = valid_r;
  assign bus.if_instr       = head_instr_r;
  assign bus.if_pc          = head_pc_r;
  assign unused_lsb_s       = ^bus.redirect_pc[1:0];

  // Handshake decode; responses outside WAIT are never written.
  always_comb begin
    req_fire_s = bus.imem_req_valid && bus.imem_req_ready;
    push_s     = (state_r == WAIT) && bus.imem_rsp_valid;
    pop_s      = valid_r && bus.if_ready;
  end

  // Buffer occupancy after this cycle's push/pop, ignoring redirect.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  // Fetch FSM with program counter and in-flight address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      pc_r          <= RESET_PC;
      inflight_pc_r <= 32'h0000_0000;
    end else if (bus.redirect_valid) begin
      pc_r <= {bus.redirect_pc[31:2], 2'b00};
      case (state_r)
        IDLE:       state_r <= REQ;
        REQ:        state_r <= req_fire_s ? DROP : REQ;
        WAIT, DROP: state_r <= bus.imem_rsp_valid ? REQ : DROP;
        default:    state_r <= IDLE;
      endcase
    end else begin
      case (state_r)
        IDLE: state_r <= REQ;
        REQ: begin
          if (req_fire_s) begin
            inflight_pc_r <= pc_r;
            pc_r          <= pc_r + 32'd4;
            state_r       <= WAIT;
          end
        end
        WAIT, DROP: begin
          if (bus.imem_rsp_valid) begin
            state_r <= REQ;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Two-entry shift buffer: head drives decode, tail holds the second word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r      <= 2'd0;
      valid_r      <= 1'b0;
      head_pc_r    <= 32'h0000_0000;
      head_instr_r <= NOP_INSTR;
      tail_pc_r    <= 32'h0000_0000;
      tail_instr_r <= NOP_INSTR;
    end else if (bus.redirect_valid) begin
      count_r <= 2'd0;
      valid_r <= 1'b0;
    end else begin
      count_r <= count_next_s;
      valid_r <= (count_next_s != 2'd0);
      if (pop_s) begin
        head_pc_r    <= tail_pc_r;
        head_instr_r <= tail_instr_r;
      end
      // A word landing in an emptying slot goes straight to the head.
      if (push_s) begin
        if ((count_r == 2'd0) || ((count_r == 2'd1) && pop_s)) begin
          head_pc_r    <= inflight_pc_r;
          head_instr_r <= bus.imem_rsp_data;
        end else begin
          tail_pc_r    <= inflight_pc_r;
          tail_instr_r <= bus.imem_rsp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: transaction-level model of the fetch
// stream (expected-word queue plus one outstanding slot) and a latency memory.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC0 = 32'h0000_0000;
  localparam logic [31:0] RESET_PC1 = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_mis = 0;
  bit   done2 = 1'b0;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit #(.RESET_PC(RESET_PC0)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus.master));
  fetch_unit #(.RESET_PC(RESET_PC1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.master));

  always #5 clk = ~clk;

  // Reference model state
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          o_busy;
  bit          o_drop;
  logic [31:0] o_addr;
  int          o_cnt;
  int          p_ready, p_ifready, p_redir, lat_min, lat_max;
  bit          force_redir;
  logic [31:0] force_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: check outputs, drive inputs, advance the model past the next edge.
  task automatic step();
    logic        rsp, fire, pop, redir, exp_rv;
    logic [31:0] rpc;
    @(negedge clk);
    if (!rst_n) begin
      check_val("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check_val("rst_imem_addr", bus.imem_addr, RESET_PC0);
      check_val("rst_if_valid", 32'(bus.if_valid), 32'd0);
      check_val("rst_if_instr", bus.if_instr, 32'h0000_0013);
      check_val("rst_if_pc", bus.if_pc, 32'h0000_0000);
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.if_ready       = 1'b0;
    end else begin
      exp_rv = !o_busy && (q.size() < 2);
      check_val("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
      if (exp_rv) check_val("imem_addr", bus.imem_addr, m_pc);
      check_val("if_valid", 32'(bus.if_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        check_val("if_pc", bus.if_pc, q[0].pc);
        check_val("if_instr", bus.if_instr, q[0].instr);
      end

      rsp   = o_busy && (o_cnt == 1);
      redir = force_redir || ($urandom_range(99) < p_redir);
      rpc   = force_redir ? force_pc : $urandom;
      force_redir = 1'b0;
      bus.imem_rsp_valid = rsp;
      bus.imem_rsp_data  = rsp ? mem_word(o_addr) : $urandom;
      bus.imem_req_ready = ($urandom_range(99) < p_ready);
      bus.if_ready       = ($urandom_range(99) < p_ifready);
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;

      fire = exp_rv && bus.imem_req_ready;
      pop  = (q.size() != 0) && bus.if_ready;
      if (o_busy && !rsp) o_cnt--;
      if (redir) begin
        q.delete();
        if (rsp) o_busy = 1'b0;
        else if (o_busy) o_drop = 1'b1;
        if (fire) begin
          o_busy = 1'b1; o_drop = 1'b1; o_addr = m_pc;
          o_cnt  = $urandom_range(lat_max, lat_min);
        end
        m_pc = {rpc[31:2], 2'b00};
      end else begin
        if (pop) void'(q.pop_front());
        if (rsp) begin
          if (!o_drop) q.push_back('{pc: o_addr, instr: mem_word(o_addr)});
          o_busy = 1'b0;
        end
        if (fire) begin
          o_busy = 1'b1; o_drop = 1'b0; o_addr = m_pc;
          o_cnt  = $urandom_range(lat_max, lat_min);
          m_pc   = m_pc + 32'd4;
        end
      end
    end
  endtask

  // Asynchronous reset of DUT, memory and model; outputs checked while low.
  task automatic do_reset(input int n);
    rst_n  = 1'b0;
    q.delete();
    m_pc   = RESET_PC0;
    o_busy = 1'b0;
    o_drop = 1'b0;
    o_cnt  = 0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin : main
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.if_ready = 1'b0;
    force_redir = 1'b0; force_pc = 32'h0;
    p_ready = 100; p_ifready = 100; p_redir = 0; lat_min = 1; lat_max = 1;

    do_reset(3);
    repeat (12) step();
    p_ifready = 0;
    repeat (10) step();
    p_ifready = 100;
    repeat (10) step();

    // Redirect to 0x100 while a 3-cycle request is outstanding.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 50 && !(o_busy && o_cnt >= 2); i++) step();
    check_val("wait_outstanding", 32'(o_busy && o_cnt >= 2), 32'd1);
    force_redir = 1'b1; force_pc = 32'h0000_0100;
    repeat (8) step();

    // Redirect to 0x203 in the same cycle as a response.
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 50 && !(o_busy && o_cnt == 1); i++) step();
    check_val("wait_rsp_cycle", 32'(o_busy && o_cnt == 1), 32'd1);
    force_redir = 1'b1; force_pc = 32'h0000_0203;
    repeat (8) step();

    p_ready = 70; p_ifready = 60; p_redir = 8; lat_min = 1; lat_max = 4;
    repeat (1500) step();

    // Reset while a word is buffered and a request is outstanding.
    p_ready = 100; p_ifready = 0; p_redir = 0; lat_min = 3; lat_max = 3;
    for (int i = 0; i < 50 && !(q.size() == 1 && o_busy); i++) step();
    check_val("wait_busy_full", 32'(q.size() == 1 && o_busy), 32'd1);
    do_reset(3);
    p_ifready = 100; lat_min = 1; lat_max = 2;
    repeat (20) step();

    for (int i = 0; i < 100 && !done2; i++) @(negedge clk);
    check_val("dut2_done", 32'(done2), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Second instance: pc wrap from RESET_PC = 0xFFFF_FFF8, always-ready 1-cycle memory.
  initial begin : wrap_drv
    logic        pend2;
    int          n2;
    logic [31:0] a2 [3];
    logic [31:0] e2 [3];
    bus2.imem_req_ready = 1'b1; bus2.imem_rsp_valid = 1'b0;
    bus2.imem_rsp_data  = 32'h0000_0013; bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0; bus2.if_ready = 1'b1;
    pend2 = 1'b0;
    n2    = 0;
    e2    = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    wait (rst_n === 1'b1);
    for (int c = 0; c < 40 && n2 < 3; c++) begin
      @(negedge clk);
      bus2.imem_rsp_valid = pend2;
      pend2 = 1'b0;
      if (bus2.imem_req_valid) begin
        a2[n2] = bus2.imem_addr;
        n2++;
        pend2 = 1'b1;
      end
    end
    @(negedge clk);
    bus2.imem_rsp_valid = pend2;
    check_val("wrap_count", 32'(n2), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < n2) check_val("wrap_addr", a2[k], e2[k]);
    end
    @(negedge clk);
    bus2.imem_rsp_valid = 1'b0;
    done2 = 1'b1;
  end

endmodule
